adder_share_arbiter: RTL and testbench

Round-robin scheduler that shares one WIDTH-bit ripple-carry adder chain (half adder at bit 0, full adders above) among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, registers its operands, runs them through the shared adder, and returns a tagged WIDTH+1-bit sum on a single response channel with backpressure. It sits between the client blocks and the adder datapath and is the only instantiator of the adder.

---
 rtl/adder_share_arbiter.sv | 104 ++++++++++
 tb/tb_adder_share_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit ripple-carry adder among NREQ requesters.
// One operation at a time: grant, register operands, add, hold the tagged sum until accepted.
module adder_share_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH:0]        rsp_sum,
    input  logic                  rsp_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    logic [IDW-1:0]   last;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [IDW-1:0]   grant;
    logic             grant_found;
    logic [WIDTH-1:0] carry;
    logic [WIDTH:0]   sum;

    // Search upward from last+1, wrapping, so the previous winner is checked last.
    // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        int idx;
        idx         = 0;
        grant       = '0;
        grant_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant       = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && grant_found) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Shared adder: half adder at bit 0, full adders above, carry-out lands in sum[WIDTH].
    assign sum[0]   = op_a[0] ^ op_b[0];
    assign carry[0] = op_a[0] & op_b[0];
    for (genvar i = 1; i < WIDTH; i++) begin : g_fa
        assign sum[i]   = op_a[i] ^ op_b[i] ^ carry[i-1];
        assign carry[i] = (op_a[i] & op_b[i]) | (carry[i-1] & (op_a[i] ^ op_b[i]));
    end
    assign sum[WIDTH] = carry[WIDTH-1];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= IDW'(NREQ - 1);
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_a   <= req_a[grant*WIDTH +: WIDTH];
                        op_b   <= req_b[grant*WIDTH +: WIDTH];
                        rsp_id <= grant;
                        last   <= grant;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum   <= sum;
                    rsp_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: a cycle-level reference model predicts grants
// and response timing, and a decoupled monitor checks responses against a scoreboard queue.
module tb_adder_share_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH:0]        rsp_sum;
    logic                  rsp_ready;

    adder_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     id;
        longint sum;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    int   rsp_log[$];
    int   exp_ids[$];

    // Requester-side stimulus state
    bit               vld[NREQ];
    bit               want[NREQ];
    bit               consumed[NREQ];
    logic [WIDTH-1:0] op_a[NREQ];
    logic [WIDTH-1:0] op_b[NREQ];
    bit               rst_cmd   = 1'b0;
    bit               rand_mode = 1'b0;
    int               rdy_mode  = 1;

    // Reference model: round-robin pointer plus response timing in cycle numbers
    int cyc         = 0;
    int m_last      = NREQ - 1;
    bit m_busy      = 1'b0;
    int m_grant_cyc = 0;
    bit m_known     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_op();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return '0;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        vld[i]  = 1'b1;
        want[i] = 1'b0;
        op_a[i] = a;
        op_b[i] = b;
    endtask

    task automatic drive_inputs();
        rst_n = rst_cmd;
        for (int i = 0; i < NREQ; i++) begin
            if (consumed[i]) begin
                consumed[i] = 1'b0;
                vld[i]      = want[i];
                if (want[i]) begin
                    op_a[i] = rand_op();
                    op_b[i] = rand_op();
                end
            end
            if (rand_mode) begin
                if (!vld[i] && $urandom_range(0, 3) == 0) begin
                    vld[i]  = 1'b1;
                    op_a[i] = rand_op();
                    op_b[i] = rand_op();
                end else if (vld[i] && $urandom_range(0, 15) == 0) begin
                    vld[i] = 1'b0;
                end
            end
            req_valid[i]              = vld[i];
            req_a[i*WIDTH +: WIDTH]   = op_a[i];
            req_b[i*WIDTH +: WIDTH]   = op_b[i];
        end
        case (rdy_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    // Predict this cycle's req_ready and rsp_valid, then advance the model across the next edge.
    task automatic model_cycle();
        logic [NREQ-1:0] exp_ready;
        bit              exp_valid;
        int              g;
        exp_ready = '0;
        g         = -1;
        if (rst_n && m_known && !m_busy) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (g < 0 && req_valid[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        if (m_known || !rst_n) check("req_ready", req_ready, exp_ready);
        exp_valid = m_busy && (cyc >= m_grant_cyc + 2);
        if (m_known) check("rsp_valid", rsp_valid, exp_valid);

        if (!rst_n) begin
            if (m_busy) sb.delete();
            m_busy  = 1'b0;
            m_last  = NREQ - 1;
            m_known = 1'b1;
        end else if (m_known) begin
            if (exp_valid && rsp_ready) begin
                m_busy = 1'b0;
            end else if (g >= 0) begin
                sb.push_back('{id: g, sum: longint'(op_a[g]) + longint'(op_b[g])});
                m_busy      = 1'b1;
                m_grant_cyc = cyc;
                m_last      = g;
                consumed[g] = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        drive_inputs();
        #1;
        model_cycle();
        cyc++;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_busy || sb.size() != 0) && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) check("idle_timeout", m_busy, 0);
    endtask

    task automatic do_one(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        set_req(i, a, b);
        step();
        wait_idle();
    endtask

    task automatic check_log(input string name);
        for (int i = 0; i < exp_ids.size(); i++) begin
            if (i < rsp_log.size()) check(name, rsp_log[i], exp_ids[i]);
            else                    check({name, "_missing"}, -1, exp_ids[i]);
        end
    endtask

    // Response monitor: pops the scoreboard on each accepted response and checks hold stability.
    bit             mon_known = 1'b0;
    bit             prev_valid = 1'b0;
    logic [IDW-1:0] prev_id;
    logic [WIDTH:0] prev_sum;
    logic [IDW-1:0] hold_id;
    logic [WIDTH:0] hold_sum;

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            mon_known  = 1'b1;
            prev_valid = 1'b0;
            hold_id    = '0;
            hold_sum   = '0;
        end else if (mon_known) begin
            if (rsp_valid) begin
                if (prev_valid) begin
                    check("hold_id_stable", rsp_id, prev_id);
                    check("hold_sum_stable", rsp_sum, prev_sum);
                end
                if (rsp_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rsp", rsp_valid, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("rsp_id", rsp_id, e.id);
                        check("rsp_sum", rsp_sum, e.sum);
                    end
                    rsp_log.push_back(int'(rsp_id));
                    hold_id    = rsp_id;
                    hold_sum   = rsp_sum;
                    prev_valid = 1'b0;
                end else begin
                    prev_valid = 1'b1;
                    prev_id    = rsp_id;
                    prev_sum   = rsp_sum;
                end
            end else begin
                prev_valid = 1'b0;
                check("idle_sum_kept", rsp_sum, hold_sum);
                if (sb.size() == 0) check("idle_id_kept", rsp_id, hold_id);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            vld[i] = 1'b0; want[i] = 1'b0; consumed[i] = 1'b0;
            op_a[i] = '0; op_b[i] = '0;
        end

        // All four requesters valid from reset: grant order 0,1,2,3, one accept every 3 cycles
        set_req(0, 8'h11, 8'h22);
        set_req(1, 8'h80, 8'h90);
        set_req(2, 8'hFE, 8'h03);
        set_req(3, 8'h00, 8'h7F);
        rdy_mode = 1;
        rst_cmd  = 1'b0;
        repeat (2) step();
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_id", rsp_id, 0);
        check("reset_rsp_sum", rsp_sum, 0);
        rst_cmd = 1'b1;
        rsp_log.delete();
        repeat (13) step();
        exp_ids = {0, 1, 2, 3};
        check_log("rr_all4");
        wait_idle();

        // Single request and carry-out boundaries
        rsp_log.delete();
        do_one(0, 8'h12, 8'h34);
        check("single_sum", rsp_sum, 9'h046);
        check("single_id", rsp_id, 0);
        exp_ids = {0};
        check_log("single_log");
        do_one(0, 8'hFF, 8'h01);
        check("carry_ff_01", rsp_sum, 9'h100);
        do_one(0, 8'hFF, 8'hFF);
        check("carry_ff_ff", rsp_sum, 9'h1FE);

        // Fairness: req0 and req2 always valid; req0 won last, so req2 leads the alternation
        rsp_log.delete();
        set_req(0, rand_op(), rand_op());
        set_req(2, rand_op(), rand_op());
        want[0] = 1'b1;
        want[2] = 1'b1;
        repeat (13) step();
        exp_ids = {2, 0, 2, 0};
        check_log("fair_alt");
        want[2] = 1'b0;
        vld[2]  = 1'b0;
        repeat (4) step();
        rsp_log.delete();
        repeat (12) step();
        exp_ids = {0, 0, 0};
        check_log("fair_only0");
        want[0] = 1'b0;
        vld[0]  = 1'b0;
        wait_idle();

        // Backpressure: response held 10 cycles with req1 pending
        rdy_mode = 0;
        set_req(0, 8'h5A, 8'hC3);
        repeat (2) step();
        set_req(1, 8'h81, 8'h7F);
        repeat (10) step();
        check("bp_valid", rsp_valid, 1);
        check("bp_id", rsp_id, 0);
        check("bp_sum", rsp_sum, 9'h11D);
        rdy_mode = 1;
        step();
        step();
        check("bp_regrant", req_ready, 4'b0010);
        wait_idle();

        // Reset while in CALC: operation discarded, req0 wins over req3 afterwards
        set_req(2, 8'h44, 8'h55);
        step();
        rst_cmd = 1'b0;
        set_req(3, 8'h33, 8'h0D);
        set_req(0, 8'h01, 8'h02);
        step();
        rst_cmd = 1'b1;
        step();
        check("midrst_valid", rsp_valid, 0);
        check("midrst_id", rsp_id, 0);
        check("midrst_sum", rsp_sum, 0);
        check("midrst_grant0", req_ready, 4'b0001);
        rsp_log.delete();
        repeat (10) step();
        exp_ids = {0, 3};
        check_log("midrst_order");
        wait_idle();

        // Randomized traffic with random backpressure and legal valid drops
        rand_mode = 1'b1;
        rdy_mode  = 2;
        repeat (600) step();
        rand_mode = 1'b0;
        rdy_mode  = 1;
        for (int i = 0; i < NREQ; i++) begin
            vld[i]  = 1'b0;
            want[i] = 1'b0;
        end
        wait_idle();
        repeat (2) step();
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
